reset_synchronizer: RTL and testbench
=====================================

# reset_synchronizer

Brings an externally generated, asynchronous active-high reset request into the `clk` domain. It produces a clean, registered reset with a minimum assertion width, for use by downstream logic in that domain. It sits at the clock-domain boundary, between a board/PLL/watchdog reset source and the local reset tree. It also reports one-cycle assertion pulses and a saturating event count for debug.

## Interface
- `STAGES`, default 2: synchronizer depth in flops; legal range ≥ 2.
- `STRETCH`, default 2: extra cycles `sync_rst` is held after the synchronized request falls; legal range ≥ 0.
- `CNT_W`, default 8: width of `rst_count`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  block reset, synchronous, active-low.
- `async_rst`  in  1  reset request, active-high, asynchronous to `clk`.
- `sync_rst`  out  1  synchronized reset, active-high, driven directly from a flop.
- `sync_rst_n`  out  1  complement of `sync_rst`, driven from its own flop, same timing.
- `rst_pulse`  out  1  one-cycle pulse on each new assertion caused by `async_rst`.
- `rst_count`  out  `CNT_W`  count of `async_rst`-caused assertions, saturating at all-ones.

## Operation
- **Synchronizer chain.**
  - Shift register `s[0..STAGES-1]`, with `s[0]` ← `async_rst` and `s[i]` ← `s[i-1]`.
  - `synced` = `s[STAGES-1]`.
- **Stretch counter `cnt`.**
  - Loaded with `STRETCH` on every edge where `synced` = 1.
  - Otherwise decremented while non-zero.
- **`sync_rst`.** Next value = next `synced` OR (next `cnt` ≠ 0), registered.
  - The output must never be combinational from the chain.
- **`rst_pulse`.** 1 for exactly one cycle after each 0→1 transition of `synced`.
  - No pulse if `sync_rst` was already held high by the stretch counter. The request is still counted.
- **`rst_count`.** Increments on each 0→1 transition of `synced`; holds at 2^CNT_W−1.
- **Block reset, `rst_n` = 0 at a rising edge:**
  - all `s[i]` ← 1 and `cnt` ← `STRETCH`;
  - `sync_rst` = 1 and `sync_rst_n` = 0;
  - `rst_pulse` = 0 and `rst_count` = 0.
- **Release of `rst_n` with `async_rst` low.**
  - The chain flushes and `sync_rst` falls as a normal deassertion.
  - No pulse is generated and nothing is counted, because `synced` was 1 during reset.
- **Short requests.** A request shorter than one clock period may be missed; this is accepted behaviour.
  - Any request sampled high at one or more edges must produce an assertion.
- **Re-assertion.** A request re-asserted during the stretch window keeps `sync_rst` high continuously.

## Timing
- E0 = first rising edge sampling `async_rst` = 1. `sync_rst` = 1 after edge E0+STAGES−1, so assertion latency is `STAGES` edges counting E0.
- `rst_pulse` is high in the cycle following edge E0+STAGES−1.
- F0 = first later edge sampling `async_rst` = 0. `sync_rst` falls after edge F0+STAGES−1+STRETCH.
- Minimum `sync_rst` width = 1 + `STRETCH` cycles.
- Defaults (`STAGES` = 2, `STRETCH` = 2): assertion 1 cycle after the first high sample; deassertion 3 cycles after the first low sample.
- `rst_n` has priority over every other input at the same edge.

## Structure
- Shared package `rst_sync_pkg` holds:
  - default constants `RST_SYNC_STAGES_DEF` = 2, `RST_SYNC_STRETCH_DEF` = 2, `RST_SYNC_CNT_W_DEF` = 8;
  - the count width type.
- Sub-module `bit_sync_chain`, parameterized by `STAGES` and reset value, implements the shift register.
- The top level holds the stretch counter, the output flops, edge detection and the event counter.

## Test plan
- **Block reset.** `rst_n` = 0 for 3 edges with `async_rst` = 0 → `sync_rst` = 1, `sync_rst_n` = 0, `rst_count` = 0, `rst_pulse` = 0. After release, `sync_rst` falls after the 4th edge (`STAGES`−1+`STRETCH`+1).
- **Long request.** 20 ns clock; `async_rst` 1 at t = 15, 0 at t = 40 (sampled high at edge t = 30) → `sync_rst` rises after t = 50, `rst_pulse` high from t = 50 to 70, and `sync_rst` falls after t = 110. `rst_count` = 1.
- **One-cycle request.** `async_rst` 1 at t = 180, 0 at t = 200 → one full assertion of 3 cycles, `rst_count` = 2, single `rst_pulse`.
- **Re-assert during stretch.** Request high for one sample, then low for one cycle, then high again → `sync_rst` never drops, `rst_count` increments twice, and only one `rst_pulse` is generated.
- **Saturation.** With `CNT_W` = 2, issue 5 separated requests → `rst_count` sticks at 3.
- **`rst_n` mid-assertion.** `rst_n` = 0 while `sync_rst` = 1 from a request → `rst_count` clears to 0 and `sync_rst` stays 1. After release with `async_rst` low, `sync_rst` deasserts with no pulse.

Source files
------------

// File: rtl/rst_sync_pkg.sv
// Shared defaults and types for the reset synchronizer slice.
// Defaults give a 2-flop chain with a 2-cycle stretch and an 8-bit event counter.
package rst_sync_pkg;

    localparam int RST_SYNC_STAGES_DEF  = 2;
    localparam int RST_SYNC_STRETCH_DEF = 2;
    localparam int RST_SYNC_CNT_W_DEF   = 8;

    typedef logic [RST_SYNC_CNT_W_DEF-1:0] rst_cnt_t;

endpackage

// File: rtl/bit_sync_chain.sv
// Single-bit shift-register synchronizer; every stage is exposed so the parent can look one stage ahead.
// One stage per clock edge. There is no backpressure. Synchronous reset loads every stage with RST_VAL.
module bit_sync_chain
    import rst_sync_pkg::*;
#(
    parameter int STAGES  = RST_SYNC_STAGES_DEF,
    parameter bit RST_VAL = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_d,
    output logic [STAGES-1:0] o_s
);

    logic [STAGES-1:0] r_s;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s <= {STAGES{RST_VAL}};
        end else begin
            r_s <= {r_s[STAGES-2:0], i_d};
        end
    end

    assign o_s = r_s;

endmodule

// File: rtl/reset_synchronizer.sv
// Synchronizes an async active-high reset request into clk with a minimum width of 1+STRETCH cycles.
// Asserts STAGES edges after the first high sample. Also emits a one-cycle pulse on each new assertion and a saturating count.
module reset_synchronizer
    import rst_sync_pkg::*;
#(
    parameter int STAGES  = RST_SYNC_STAGES_DEF,
    parameter int STRETCH = RST_SYNC_STRETCH_DEF,
    parameter int CNT_W   = RST_SYNC_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             async_rst,
    output logic             sync_rst,
    output logic             sync_rst_n,
    output logic             rst_pulse,
    output logic [CNT_W-1:0] rst_count
);

    localparam int SW = (STRETCH > 0) ? $clog2(STRETCH + 1) : 1;
    localparam logic [SW-1:0] STRETCH_V = SW'(STRETCH);

    logic [STAGES-1:0] w_s;
    logic              w_synced;
    logic              w_synced_nxt;
    logic              w_rise;
    logic [SW-1:0]     w_cnt_nxt;
    logic              w_sync_rst_nxt;

    logic [SW-1:0]     r_cnt;
    logic              r_sync_rst;
    logic              r_sync_rst_n;
    logic              r_pulse;
    logic [CNT_W-1:0]  r_count;

    bit_sync_chain #(
        .STAGES  (STAGES),
        .RST_VAL (1'b1)
    ) u_chain (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (async_rst),
        .o_s     (w_s)
    );

    // The penultimate stage is what synced will hold after this edge, so
    // the output flop sees "next synced" without adding a cycle of latency.
    assign w_synced     = w_s[STAGES-1];
    assign w_synced_nxt = w_s[STAGES-2];
    assign w_rise       = w_synced_nxt & ~w_synced;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_synced) begin
            w_cnt_nxt = STRETCH_V;
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - SW'(1);
        end
    end

    assign w_sync_rst_nxt = w_synced_nxt | (w_cnt_nxt != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= STRETCH_V;
            r_sync_rst   <= 1'b1;
            r_sync_rst_n <= 1'b0;
            r_pulse      <= 1'b0;
            r_count      <= '0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_sync_rst   <= w_sync_rst_nxt;
            r_sync_rst_n <= ~w_sync_rst_nxt;
            // A rise that lands inside an ongoing stretch is counted but not pulsed.
            r_pulse      <= w_rise & ~r_sync_rst;
            if (w_rise && (r_count != '1)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign sync_rst   = r_sync_rst;
    assign sync_rst_n = r_sync_rst_n;
    assign rst_pulse  = r_pulse;
    assign rst_count  = r_count;

endmodule

// File: tb/tb_reset_synchronizer.sv
// Scoreboard bench: a window-based reference of the reset timing pushes expected outputs per edge.
// A wide-counter instance and a CNT_W=2 instance share the same stimulus.
module tb_reset_synchronizer;
    import rst_sync_pkg::*;

    localparam int STG = 2;
    localparam int STR = 2;

    logic       clk;
    logic       rst_n;
    logic       async_rst;
    logic       sync_rst;
    logic       sync_rst_n;
    logic       rst_pulse;
    rst_cnt_t   rst_count;
    logic       s_sync_rst;
    logic       s_sync_rst_n;
    logic       s_rst_pulse;
    logic [1:0] s_rst_count;

    reset_synchronizer #(.STAGES(STG), .STRETCH(STR), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_rst  (async_rst),
        .sync_rst   (sync_rst),
        .sync_rst_n (sync_rst_n),
        .rst_pulse  (rst_pulse),
        .rst_count  (rst_count)
    );

    reset_synchronizer #(.STAGES(STG), .STRETCH(STR), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_rst  (async_rst),
        .sync_rst   (s_sync_rst),
        .sync_rst_n (s_sync_rst_n),
        .rst_pulse  (s_rst_pulse),
        .rst_count  (s_rst_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic       sr;
        logic       pulse;
        rst_cnt_t   cnt;
        logic [1:0] cnt_s;
    } exp_t;

    exp_t q[$];

    int n_chk   = 0;
    int n_pass  = 0;
    int n_pulse = 0;
    int n_rise  = 0;
    logic prev_obs_sr = 1'b1;

    // Reference state: h[j] is the request sampled j edges ago (reset fills with ones).
    logic [15:0] h;
    logic        m_syn_prev;
    logic        m_sr_prev;
    rst_cnt_t    m_cnt;
    logic [1:0]  m_cnt_s;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_step(input logic rn, input logic a, output exp_t e);
        logic syn;
        logic sr;
        logic rise;
        if (!rn) begin
            h       = '1;
            syn     = 1'b1;
            sr      = 1'b1;
            e.pulse = 1'b0;
            m_cnt   = '0;
            m_cnt_s = '0;
        end else begin
            h   = {h[14:0], a};
            syn = h[STG-1];
            sr  = 1'b0;
            for (int j = STG - 1; j <= STG - 1 + STR; j++) sr = sr | h[j];
            rise    = syn & ~m_syn_prev;
            e.pulse = rise & ~m_sr_prev;
            if (rise && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            if (rise && m_cnt_s != 2'd3) m_cnt_s = m_cnt_s + 2'd1;
        end
        e.sr       = sr;
        e.cnt      = m_cnt;
        e.cnt_s    = m_cnt_s;
        m_syn_prev = syn;
        m_sr_prev  = sr;
    endtask

    task automatic cyc(input logic rn, input logic a);
        exp_t e;
        exp_t got;
        rst_n     = rn;
        async_rst = a;
        model_step(rn, a, e);
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got = q.pop_front();
        chk("sync_rst",   {31'd0, sync_rst},     {31'd0, got.sr});
        chk("sync_rst_n", {31'd0, sync_rst_n},   {31'd0, ~got.sr});
        chk("rst_pulse",  {31'd0, rst_pulse},    {31'd0, got.pulse});
        chk("rst_count",  {24'd0, rst_count},    {24'd0, got.cnt});
        chk("sat_count",  {30'd0, s_rst_count},  {30'd0, got.cnt_s});
        chk("sat_sync_rst", {31'd0, s_sync_rst}, {31'd0, got.sr});
        if (rst_pulse) n_pulse++;
        if (sync_rst && !prev_obs_sr) n_rise++;
        prev_obs_sr = sync_rst;
    endtask

    initial begin
        int fall;
        int w;
        int p0;
        int r0;
        rst_n      = 1'b0;
        async_rst  = 1'b0;
        h          = '1;
        m_syn_prev = 1'b1;
        m_sr_prev  = 1'b1;
        m_cnt      = '0;
        m_cnt_s    = '0;

        // Block reset for three edges, then release with the request low.
        repeat (3) cyc(1'b0, 1'b0);
        chk("rst_sync_rst", {31'd0, sync_rst}, 32'd1);
        chk("rst_count0", {24'd0, rst_count}, 32'd0);
        fall = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 1'b0);
            if (fall == 0 && !sync_rst) fall = i;
        end
        chk("release_fall_edge", fall, 32'd4);
        chk("release_pulses", n_pulse, 32'd0);

        // Long request: three high samples -> 3 + STRETCH cycles of assertion.
        w = 0;
        repeat (3) begin cyc(1'b1, 1'b1); if (sync_rst) w++; end
        repeat (8) begin cyc(1'b1, 1'b0); if (sync_rst) w++; end
        chk("long_width", w, 32'd5);
        chk("long_count", {24'd0, rst_count}, 32'd1);

        // One-sample request -> 1 + STRETCH cycles, single pulse.
        p0 = n_pulse;
        w  = 0;
        cyc(1'b1, 1'b1); if (sync_rst) w++;
        repeat (8) begin cyc(1'b1, 1'b0); if (sync_rst) w++; end
        chk("oneshot_width", w, 32'd3);
        chk("oneshot_count", {24'd0, rst_count}, 32'd2);
        chk("oneshot_pulses", n_pulse - p0, 32'd1);

        // Re-assert inside the stretch window: one continuous assertion, two counts, one pulse.
        p0 = n_pulse;
        r0 = n_rise;
        w  = 0;
        cyc(1'b1, 1'b1); if (sync_rst) w++;
        cyc(1'b1, 1'b0); if (sync_rst) w++;
        cyc(1'b1, 1'b1); if (sync_rst) w++;
        repeat (8) begin cyc(1'b1, 1'b0); if (sync_rst) w++; end
        chk("reassert_width", w, 32'd5);
        chk("reassert_rises", n_rise - r0, 32'd1);
        chk("reassert_pulses", n_pulse - p0, 32'd1);
        chk("reassert_count", {24'd0, rst_count}, 32'd4);

        // Five separated requests: the 2-bit counter sticks at 3.
        repeat (5) begin
            cyc(1'b1, 1'b1);
            repeat (6) cyc(1'b1, 1'b0);
        end
        chk("sat_stuck", {30'd0, s_rst_count}, 32'd3);
        chk("wide_count", {24'd0, rst_count}, 32'd9);

        // Block reset while asserted by a request.
        p0 = n_pulse;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        chk("mid_asserted", {31'd0, sync_rst}, 32'd1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("mid_count_clr", {24'd0, rst_count}, 32'd0);
        chk("mid_still_high", {31'd0, sync_rst}, 32'd1);
        repeat (8) cyc(1'b1, 1'b0);
        chk("mid_released", {31'd0, sync_rst}, 32'd0);
        chk("mid_pulses", n_pulse - p0, 32'd1);
        chk("mid_count_after", {24'd0, rst_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
